// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and register-index helpers for the scoreboarded register file.
package regfile_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 3;
   localparam int ZERO_REG = 0;
   localparam logic [7:0] DEF_CONST_VAL = 8'h7F;
   function automatic int const_reg(input int addr_w);
      return (1 << addr_w) - 1;
   endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits, set/clear priority and issue stall generation.
// With REGFILE_BYPASS_EN, a same-cycle write-back hides a source's busy bit from the stall.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int HAS_CONST = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_iss_valid,
   input  logic                   i_iss_wr,
   input  logic [ADDR_W-1:0]      i_iss_dst,
   input  logic [ADDR_W-1:0]      i_iss_src_a,
   input  logic [ADDR_W-1:0]      i_iss_src_b,
   input  logic                   i_wb_en,
   input  logic [ADDR_W-1:0]      i_wb_addr,
   output logic                   o_stall,
   output logic [(1<<ADDR_W)-1:0] o_busy
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
   localparam logic [ADDR_W-1:0] CR = ADDR_W'(const_reg(ADDR_W));
   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_clr;
   logic [DEPTH-1:0] w_set;
   logic [DEPTH-1:0] w_src_busy;
   logic             w_dst_ro;
   logic             w_accept;
   assign w_clr = DEPTH'(i_wb_en) << i_wb_addr;
`ifdef REGFILE_BYPASS_EN
   assign w_src_busy = r_busy & ~w_clr;
`else
   assign w_src_busy = r_busy;
`endif
   // WAW always looks at registered busy so a new producer never races the old one
   assign o_stall = i_iss_valid & (w_src_busy[i_iss_src_a] | w_src_busy[i_iss_src_b] |
                                   (i_iss_wr & r_busy[i_iss_dst]));
   assign w_accept = i_iss_valid & ~o_stall;
   assign w_dst_ro = (i_iss_dst == ZR) | ((HAS_CONST != 0) && (i_iss_dst == CR));
   assign w_set = DEPTH'(w_accept & i_iss_wr & ~w_dst_ro) << i_iss_dst;
   always_ff @(posedge clk) begin
      if (rst) r_busy <= '0;
      else     r_busy <= (r_busy & ~w_clr) | w_set;
   end
   assign o_busy = r_busy;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W register file with zero/constant registers and hazard scoreboard.
// Optional same-cycle write-back forwarding enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int HAS_CONST = 1,
   parameter logic [DATA_W-1:0] CONST_VAL = DATA_W'(DEF_CONST_VAL)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_W-1:0]      RA,
   input  logic [ADDR_W-1:0]      RB,
   output logic [DATA_W-1:0]      A,
   output logic [DATA_W-1:0]      B,
   input  logic                   RegWrite,
   input  logic [ADDR_W-1:0]      RDo,
   input  logic [DATA_W-1:0]      wb_data,
   input  logic                   iss_valid,
   input  logic                   iss_wr,
   input  logic [ADDR_W-1:0]      iss_dst,
   input  logic [ADDR_W-1:0]      iss_src_a,
   input  logic [ADDR_W-1:0]      iss_src_b,
   output logic                   stall,
   output logic [(1<<ADDR_W)-1:0] busy
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
   localparam logic [ADDR_W-1:0] CR = ADDR_W'(const_reg(ADDR_W));
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_we;
   logic              w_byp;
   assign w_we = RegWrite & (RDo != ZR) & ~((HAS_CONST != 0) && (RDo == CR));
`ifdef REGFILE_BYPASS_EN
   assign w_byp = RegWrite;
`else
   assign w_byp = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_we) begin
         r_mem[RDo] <= wb_data;
      end
   end
   // zero and constant registers win over forwarding, forwarding wins over storage
   assign A = (RA == ZR) ? '0 : ((HAS_CONST != 0) && (RA == CR)) ? CONST_VAL :
              (w_byp && (RDo == RA)) ? wb_data : r_mem[RA];
   assign B = (RB == ZR) ? '0 : ((HAS_CONST != 0) && (RB == CR)) ? CONST_VAL :
              (w_byp && (RDo == RB)) ? wb_data : r_mem[RB];
   rf_scoreboard #(.ADDR_W(ADDR_W), .HAS_CONST(HAS_CONST)) u_sb (
      .clk         (clk),
      .rst         (rst),
      .i_iss_valid (iss_valid),
      .i_iss_wr    (iss_wr),
      .i_iss_dst   (iss_dst),
      .i_iss_src_a (iss_src_a),
      .i_iss_src_b (iss_src_b),
      .i_wb_en     (RegWrite),
      .i_wb_addr   (RDo),
      .o_stall     (stall),
      .o_busy      (busy)
   );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and randomized checks against a behavioural register-file model.
module tb_regfile_scoreboard;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] RA, RB, RDo, iss_dst, iss_src_a, iss_src_b;
   logic [7:0] A, B, wb_data;
   logic       RegWrite, iss_valid, iss_wr, stall;
   logic [7:0] busy;
   int         checks = 0;
   int         failures = 0;
   logic [7:0] mem [8];
   bit         pend [8];

   always #5 clk = ~clk;

   regfile_scoreboard dut (
      .clk(clk), .rst(rst), .RA(RA), .RB(RB), .A(A), .B(B),
      .RegWrite(RegWrite), .RDo(RDo), .wb_data(wb_data),
      .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_dst(iss_dst),
      .iss_src_a(iss_src_a), .iss_src_b(iss_src_b),
      .stall(stall), .busy(busy)
   );

   function automatic bit read_only(input int r);
      return r == 0 || r == 7;
   endfunction

   function automatic logic [7:0] m_read(input int r);
      if (r == 0) return 8'h00;
      if (r == 7) return 8'h7F;
      if (BYP && RegWrite && int'(RDo) == r) return wb_data;
      return mem[r];
   endfunction

   function automatic bit m_src_busy(input int r);
      return pend[r] && !(BYP && RegWrite && int'(RDo) == r);
   endfunction

   function automatic bit m_stall();
      if (!iss_valid) return 1'b0;
      return m_src_busy(int'(iss_src_a)) || m_src_busy(int'(iss_src_b)) ||
             (iss_wr && pend[int'(iss_dst)]);
   endfunction

   function automatic logic [7:0] m_busy();
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = pend[i];
      return v;
   endfunction

   task automatic idle();
      rst = 0; RA = 0; RB = 0; RegWrite = 0; RDo = 0; wb_data = 0;
      iss_valid = 0; iss_wr = 0; iss_dst = 0; iss_src_a = 0; iss_src_b = 0;
   endtask

   // advance the model with the inputs currently applied, then move to the next cycle
   task automatic cyc();
      bit acc;
      acc = iss_valid && !m_stall() && iss_wr && !read_only(int'(iss_dst));
      if (rst) begin
         for (int i = 0; i < 8; i++) begin mem[i] = 0; pend[i] = 0; end
      end else begin
         if (RegWrite && !read_only(int'(RDo))) mem[int'(RDo)] = wb_data;
         if (RegWrite) pend[int'(RDo)] = 0;
         if (acc) pend[int'(iss_dst)] = 1;
      end
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle(); rst = 1; cyc(); rst = 0;
      RA = 0; RB = 7; #1;
      checks++; if (A !== 8'h00) begin failures++; $display("FAIL reset_A0 got=%h exp=00", A); end
      checks++; if (B !== 8'h7F) begin failures++; $display("FAIL reset_B7 got=%h exp=7f", B); end
      RA = 3; #1;
      checks++; if (A !== 8'h00) begin failures++; $display("FAIL reset_A3 got=%h exp=00", A); end
      checks++; if (busy !== 8'h00) begin failures++; $display("FAIL reset_busy got=%h exp=00", busy); end
   endtask

   task automatic test_write();
      idle(); RegWrite = 1; RDo = 3; wb_data = 8'hA5; RA = 3; #1;
      checks++; if (A !== (BYP ? 8'hA5 : 8'h00)) begin failures++; $display("FAIL wr_same_cycle got=%h exp=%h", A, BYP ? 8'hA5 : 8'h00); end
      cyc(); idle(); RA = 3; #1;
      checks++; if (A !== 8'hA5) begin failures++; $display("FAIL wr_readback got=%h exp=a5", A); end
      RegWrite = 1; RDo = 0; wb_data = 8'hFF; cyc();
      RDo = 7; cyc(); idle(); RA = 0; RB = 7; #1;
      checks++; if (A !== 8'h00) begin failures++; $display("FAIL wr_zero_reg got=%h exp=00", A); end
      checks++; if (B !== 8'h7F) begin failures++; $display("FAIL wr_const_reg got=%h exp=7f", B); end
      checks++; if (busy !== 8'h00) begin failures++; $display("FAIL wr_ro_busy got=%h exp=00", busy); end
   endtask

   task automatic test_raw();
      idle(); iss_valid = 1; iss_wr = 1; iss_dst = 4; iss_src_a = 1; iss_src_b = 2; #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_first_issue got=%b exp=0", stall); end
      cyc(); idle(); iss_valid = 1; iss_src_a = 4; iss_src_b = 1; #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL raw_stall got=%b exp=1", stall); end
      checks++; if (busy !== 8'h10) begin failures++; $display("FAIL raw_busy got=%h exp=10", busy); end
      RegWrite = 1; RDo = 4; wb_data = 8'h44; #1;
      checks++; if (stall !== !BYP) begin failures++; $display("FAIL raw_wb_cycle got=%b exp=%b", stall, !BYP); end
      cyc(); RegWrite = 0; #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_after_wb got=%b exp=0", stall); end
      cyc(); idle();
   endtask

   task automatic test_set_wins();
      idle(); iss_valid = 1; iss_wr = 1; iss_dst = 2; RegWrite = 1; RDo = 2; wb_data = 8'h22; #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL setwin_stall got=%b exp=0", stall); end
      cyc(); idle(); #1;
      checks++; if (busy[2] !== 1'b1) begin failures++; $display("FAIL setwin_busy2 got=%b exp=1", busy[2]); end
      RegWrite = 1; RDo = 2; wb_data = 8'h23; cyc(); idle();
   endtask

   task automatic test_waw();
      idle(); iss_valid = 1; iss_wr = 1; iss_dst = 5; cyc();
      iss_src_a = 1; iss_src_b = 1; #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL waw_stall got=%b exp=1", stall); end
      iss_valid = 0; #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL waw_invalid got=%b exp=0", stall); end
      iss_valid = 1; iss_wr = 0; #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL waw_nowr got=%b exp=0", stall); end
   endtask

   task automatic test_reset_mid();
      idle(); RegWrite = 1; RDo = 3; wb_data = 8'h99; iss_valid = 1; iss_wr = 1; iss_dst = 3; cyc();
      idle(); #1;
      checks++; if (busy[3] !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%b exp=1", busy[3]); end
      rst = 1; cyc(); rst = 0; RA = 3; #1;
      checks++; if (busy !== 8'h00) begin failures++; $display("FAIL rstmid_busy got=%h exp=00", busy); end
      checks++; if (A !== 8'h00) begin failures++; $display("FAIL rstmid_reg3 got=%h exp=00", A); end
      RegWrite = 1; RDo = 3; wb_data = 8'h3C; #1;
      checks++; if (A !== (BYP ? 8'h3C : 8'h00)) begin failures++; $display("FAIL rstmid_byp got=%h exp=%h", A, BYP ? 8'h3C : 8'h00); end
      cyc(); idle(); RA = 3; #1;
      checks++; if (A !== 8'h3C) begin failures++; $display("FAIL rstmid_late_wb got=%h exp=3c", A); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 49) == 0);
         RA = 3'($urandom); RB = 3'($urandom);
         RegWrite = $urandom_range(0, 2) == 0; RDo = 3'($urandom); wb_data = 8'($urandom);
         iss_valid = $urandom_range(0, 3) != 0; iss_wr = $urandom_range(0, 3) != 0;
         iss_dst = 3'($urandom); iss_src_a = 3'($urandom); iss_src_b = 3'($urandom);
         #1;
         checks++; if (A !== m_read(int'(RA))) begin failures++; $display("FAIL rnd_A n=%0d got=%h exp=%h", n, A, m_read(int'(RA))); end
         checks++; if (B !== m_read(int'(RB))) begin failures++; $display("FAIL rnd_B n=%0d got=%h exp=%h", n, B, m_read(int'(RB))); end
         checks++; if (stall !== m_stall()) begin failures++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall, m_stall()); end
         checks++; if (busy !== m_busy()) begin failures++; $display("FAIL rnd_busy n=%0d got=%h exp=%h", n, busy, m_busy()); end
         cyc();
      end
      idle();
   endtask

   initial begin
      idle();
      @(negedge clk); #1;
      test_reset();
      test_write();
      test_raw();
      test_set_wins();
      test_waw();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
